// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Shares one external combinational add/subtract unit among four requesters.
// A round-robin arbiter picks a winner in IDLE and latches its operands and
// opcode into the au_* registers that feed the shared unit. The unit settles
// during EXEC, and the closing EXEC edge captures its sum, carry and signed
// overflow. DONE then pulses the winner's done bit for one cycle.
//
// Handshake: a requester holds req[i] with valid op_a/op_b/op_sub until it
// sees grant[i]. Operands are sampled only on the IDLE->EXEC edge. Once
// grant[i] is high, the requester may change its operands. It must drop
// req[i] by the edge that ends its DONE cycle, otherwise the request counts
// as a new one. done[i] marks the single cycle in which result/carry/ovf
// hold that requester's answer. The results stay valid until the next
// capture.
//
// Ports
//   clock, resetn       clock (rising edge), asynchronous active-low reset
//   req[3:0]            request per requester
//   op_sub[3:0]         opcode per requester (0 add, 1 subtract A-B)
//   op_a, op_b          packed operands, requester i at [i*N +: N]
//   grant[3:0]          one-hot winner during EXEC and DONE
//   done[3:0]           one-hot, one-cycle completion pulse (DONE)
//   result/carry/ovf    registered sum, carry-out (no-borrow for sub), overflow
//   busy                high in EXEC and DONE
//   au_a/au_b/au_addsub registered operands/opcode to the shared unit
//   au_s/au_cout        shared unit sum and carry-out
//   dbg_state           current FSM state (0 IDLE, 1 EXEC, 2 DONE)
// -----------------------------------------------------------------------------
module addsub_arbiter #(
    parameter int N = 5
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [3:0]     req,
    input  logic [3:0]     op_sub,
    input  logic [4*N-1:0] op_a,
    input  logic [4*N-1:0] op_b,
    output logic [3:0]     grant,
    output logic [3:0]     done,
    output logic [N-1:0]   result,
    output logic           carry,
    output logic           ovf,
    output logic           busy,
    output logic [N-1:0]   au_a,
    output logic [N-1:0]   au_b,
    output logic           au_addsub,
    input  logic [N-1:0]   au_s,
    input  logic           au_cout,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last;
    logic [1:0] winner;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       ovf_nxt;

    // Round-robin search: start one past the last served requester and wrap.
    // k = 4 wraps back to 'last' itself. This lets a lone repeat requester
    // be served again.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Signed overflow: the effective B sign (inverted for subtract) matches
    // the A sign, and the result sign differs from A.
    assign ovf_nxt = (au_a[N-1] == (au_b[N-1] ^ au_addsub)) && (au_s[N-1] != au_a[N-1]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|req) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant     <= '0;
            done      <= '0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            au_a      <= '0;
            au_b      <= '0;
            au_addsub <= 1'b0;
            winner    <= 2'd0;
            last      <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        au_a      <= op_a[pick*N +: N];
                        au_b      <= op_b[pick*N +: N];
                        au_addsub <= op_sub[pick];
                        winner    <= pick;
                        grant     <= 4'b0001 << pick;
                    end
                end
                ST_EXEC: begin
                    result <= au_s;
                    carry  <= au_cout;
                    ovf    <= ovf_nxt;
                    done   <= 4'b0001 << winner;
                end
                ST_DONE: begin
                    done  <= '0;
                    grant <= '0;
                    last  <= winner;
                end
                default: begin
                    done  <= '0;
                    grant <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addsub_arbiter
//
// Drives directed vectors into addsub_arbiter. It also models the external
// shared add/subtract unit. A transaction-level model inside the bench
// predicts every output on every cycle, and directed tasks pin the model with
// hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_addsub_arbiter;

    localparam int N = 5;

    logic           clock;
    logic           resetn;
    logic [3:0]     req;
    logic [3:0]     op_sub;
    logic [4*N-1:0] op_a;
    logic [4*N-1:0] op_b;
    logic [3:0]     grant;
    logic [3:0]     done;
    logic [N-1:0]   result;
    logic           carry;
    logic           ovf;
    logic           busy;
    logic [N-1:0]   au_a;
    logic [N-1:0]   au_b;
    logic           au_addsub;
    logic [N-1:0]   au_s;
    logic           au_cout;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;

    addsub_arbiter #(.N(N)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req      (req),
        .op_sub   (op_sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .grant    (grant),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .ovf      (ovf),
        .busy     (busy),
        .au_a     (au_a),
        .au_b     (au_b),
        .au_addsub(au_addsub),
        .au_s     (au_s),
        .au_cout  (au_cout),
        .dbg_state(dbg_state)
    );

    // Shared AddSubNbit unit: A + (B xor sub) + sub.
    assign {au_cout, au_s} = {1'b0, au_a} + {1'b0, au_b ^ {N{au_addsub}}} + (N+1)'(au_addsub);

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a request, 1 operation in flight, 2 answer shown
    int m_phase = 0;
    int m_last  = 3;
    int m_win   = 0;
    int m_a     = 0;
    int m_b     = 0;
    int m_sub   = 0;
    int m_res   = 0;
    int m_c     = 0;
    int m_o     = 0;

    function automatic int to_signed(input int v);
        return (v >= 16) ? v - 32 : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = 3; m_win = 0;
        m_a = 0; m_b = 0; m_sub = 0;
        m_res = 0; m_c = 0; m_o = 0;
    endtask

    task automatic model_step();
        int sv;
        case (m_phase)
            0: begin
                if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        int idx;
                        idx = (m_last + k) % 4;
                        if (req[idx]) begin
                            m_win = idx;
                            break;
                        end
                    end
                    m_a     = int'(op_a[m_win*N +: N]);
                    m_b     = int'(op_b[m_win*N +: N]);
                    m_sub   = int'(op_sub[m_win]);
                    m_phase = 1;
                end
            end
            1: begin
                if (m_sub != 0) begin
                    m_res = (m_a - m_b + 32) % 32;
                    m_c   = (m_a >= m_b) ? 1 : 0;
                    sv    = to_signed(m_a) - to_signed(m_b);
                end else begin
                    m_res = (m_a + m_b) % 32;
                    m_c   = (m_a + m_b >= 32) ? 1 : 0;
                    sv    = to_signed(m_a) + to_signed(m_b);
                end
                m_o     = (sv > 15 || sv < -16) ? 1 : 0;
                m_phase = 2;
            end
            default: begin
                m_last  = m_win;
                m_phase = 0;
            end
        endcase
    endtask

    // Single compare process: update the model on each edge, then check the
    // DUT outputs just after the edge.
    always @(posedge clock) begin
        if (!resetn) model_reset();
        else         model_step();
        #1;
        chk("grant",     int'(grant),     (m_phase != 0) ? (1 << m_win) : 0);
        chk("done",      int'(done),      (m_phase == 2) ? (1 << m_win) : 0);
        chk("busy",      int'(busy),      (m_phase != 0) ? 1 : 0);
        chk("result",    int'(result),    m_res);
        chk("carry",     int'(carry),     m_c);
        chk("ovf",       int'(ovf),       m_o);
        chk("au_a",      int'(au_a),      m_a);
        chk("au_b",      int'(au_b),      m_b);
        chk("au_addsub", int'(au_addsub), m_sub);
        chk("onehot_done", ($countones(done) <= 1) ? 1 : 0, 1);
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input int a, input int b, input int s);
        op_a[i*N +: N] = a[N-1:0];
        op_b[i*N +: N] = b[N-1:0];
        op_sub[i]      = s[0];
    endtask

    // Wait for a done pulse, at most 'budget' edges. Sampled 1 time unit after the edge.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (done != 4'b0000) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    // One request from requester i. The bench checks latency, grant, done and the result literals.
    task automatic run_op(input string name, input int i, input int a, input int b, input int s,
                          input int exp_res, input int exp_c, input int exp_o);
        int cyc;
        @(negedge clock);
        set_op(i, a, b, s);
        req = 4'b0001 << i;
        @(posedge clock);
        #1;
        chk({name, "_grant_t1"}, int'(grant), 1 << i);
        wait_done(8, cyc);
        chk({name, "_latency"}, cyc, 1);
        chk({name, "_grant_t2"}, int'(grant), 1 << i);
        chk({name, "_done"},     int'(done),  1 << i);
        chk({name, "_result"},   int'(result), exp_res);
        chk({name, "_carry"},    int'(carry),  exp_c);
        chk({name, "_ovf"},      int'(ovf),    exp_o);
        @(negedge clock);
        req = 4'b0000;
        @(posedge clock);
        #1;
        chk({name, "_done_drop"}, int'(done), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        resetn = 1'b0;
        req    = 4'b0000;
        op_sub = 4'b0000;
        op_a   = '0;
        op_b   = '0;
        #1;
        chk("rst_grant",  int'(grant),  0);
        chk("rst_done",   int'(done),   0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_result", int'(result), 0);
        chk("rst_au_a",   int'(au_a),   0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Directed arithmetic vectors.
        run_op("add_7_9",   0, 7,  9, 0, 16, 0, 1);
        run_op("sub_3_5",   2, 3,  5, 1, 30, 0, 0);
        run_op("sub_5_3",   1, 5,  3, 1,  2, 1, 0);
        run_op("sub_m16_1", 3, 16, 1, 1, 15, 1, 1);

        // Operand change after grant: the sampled value wins.
        @(negedge clock);
        set_op(0, 4, 1, 0);
        req = 4'b0001;
        @(posedge clock);
        #1;
        chk("chg_grant", int'(grant), 1);
        @(negedge clock);
        set_op(0, 20, 9, 1);
        wait_done(8, cyc);
        chk("chg_result", int'(result), 5);
        chk("chg_au_a",   int'(au_a),   4);
        @(negedge clock);
        req = 4'b0000;
        @(posedge clock);

        // Round robin from reset with all requests held.
        @(negedge clock);
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 2, 0);
        req = 4'b1111;
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_done(12, cyc);
            chk("rr_done", int'(done), 1 << exp_order[k]);
            chk("rr_result", int'(result), exp_order[k] + 3);
            if (k > 0) chk("rr_spacing", cyc, 3);
        end
        @(negedge clock);
        req = 4'b0000;
        @(posedge clock);

        // Reset in the middle of EXEC.
        @(negedge clock);
        set_op(1, 3, 4, 0);
        req = 4'b0010;
        @(posedge clock);
        #1;
        chk("mid_grant_before", int'(grant), 2);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_grant",  int'(grant),  0);
        chk("mid_done",   int'(done),   0);
        chk("mid_busy",   int'(busy),   0);
        chk("mid_result", int'(result), 0);
        chk("mid_au_a",   int'(au_a),   0);
        @(posedge clock);
        #1;
        chk("mid_no_done", int'(done), 0);
        @(negedge clock);
        req    = 4'b1111;
        resetn = 1'b1;
        wait_done(8, cyc);
        chk("post_rst_first", int'(done), 1);
        chk("post_rst_result", int'(result), 3);
        @(negedge clock);
        req = 4'b0000;
        repeat (3) @(posedge clock);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
